aes_job_scheduler: RTL and testbench

- Shares one AES engine between two requesters: an encrypt client and a decrypt client.
- The engine is the Encryption/Decryption pair, muxed by mode, with a start/done interface.
- The block arbitrates round-robin, latches one job (data, key, mode) and issues a single-cycle start.
- It waits for done with a timeout guard, then holds the result on a valid/ready response port. It sits between the SPI_Master-side request logic and the AES cores.

---
 rtl/aes_job_scheduler.sv | 134 +++++++++++++
 tb/tb_aes_job_scheduler.sv | 385 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_job_scheduler.sv
// Round-robin scheduler sharing one AES engine between an encrypt and a decrypt
// requester: accepts one job, pulses eng_start, waits for eng_done or timeout, returns the result.
module aes_job_scheduler #(
  parameter int Nk      = 4,
  parameter int Nr      = 10,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enc_req_valid,
  output logic             enc_req_ready,
  input  logic [127:0]     enc_data,
  input  logic             dec_req_valid,
  output logic             dec_req_ready,
  input  logic [127:0]     dec_data,
  input  logic [Nk*32-1:0] key_in,
  output logic             eng_start,
  output logic             eng_mode,
  output logic [127:0]     eng_data,
  output logic [Nk*32-1:0] eng_key,
  input  logic             eng_done,
  input  logic [127:0]     eng_result,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_mode,
  output logic [127:0]     rsp_data,
  output logic             rsp_error,
  output logic             busy,
  output logic [7:0]       err_count,
  output logic [1:0]       state_dbg
);

  localparam int CW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  // Nr only configures the external engine; a bad TIMEOUT would make the guard unreachable.
  if (TIMEOUT < 2 || Nr < 1) begin : g_param_check
    $error("aes_job_scheduler: TIMEOUT must be >= 2 and Nr >= 1");
  end

  state_t         state;
  logic           last_dec;
  logic [CW-1:0]  wait_cnt;
  logic [CW-1:0]  wait_nxt;
  logic           enc_win;
  logic           dec_win;

  // Handshakes: a transfer happens on a rising clk edge where valid & ready are both high.
  // Requesters may drop valid before ready (nothing happens); rsp_* hold steady while
  // rsp_valid is high until rsp_ready is seen. Request readies are combinational.
  assign enc_win       = enc_req_valid & (~dec_req_valid | last_dec);
  assign dec_win       = dec_req_valid & (~enc_req_valid | ~last_dec);
  assign enc_req_ready = (state == S_IDLE) & enc_win;
  assign dec_req_ready = (state == S_IDLE) & dec_win;
  assign busy          = (state != S_IDLE);
  assign state_dbg     = state;
  assign wait_nxt      = wait_cnt + CW'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      last_dec  <= 1'b1;
      wait_cnt  <= '0;
      eng_start <= 1'b0;
      eng_mode  <= 1'b0;
      eng_data  <= '0;
      eng_key   <= '0;
      rsp_valid <= 1'b0;
      rsp_mode  <= 1'b0;
      rsp_data  <= '0;
      rsp_error <= 1'b0;
      err_count <= '0;
    end else begin
      eng_start <= 1'b0;
      case (state)
        S_IDLE: begin
          if (enc_req_ready) begin
            eng_data  <= enc_data;
            eng_key   <= key_in;
            eng_mode  <= 1'b0;
            last_dec  <= 1'b0;
            eng_start <= 1'b1;
            state     <= S_ISSUE;
          end else if (dec_req_ready) begin
            eng_data  <= dec_data;
            eng_key   <= key_in;
            eng_mode  <= 1'b1;
            last_dec  <= 1'b1;
            eng_start <= 1'b1;
            state     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          wait_cnt <= '0;
          state    <= S_WAIT;
        end
        S_WAIT: begin
          wait_cnt <= wait_nxt;
          // Testing the post-increment count puts rsp_valid exactly TIMEOUT cycles after eng_start.
          if (eng_done) begin
            rsp_data  <= eng_result;
            rsp_error <= 1'b0;
            rsp_mode  <= eng_mode;
            rsp_valid <= 1'b1;
            state     <= S_RESP;
          end else if (wait_nxt == CW'(TIMEOUT - 1)) begin
            rsp_data  <= '0;
            rsp_error <= 1'b1;
            rsp_mode  <= eng_mode;
            rsp_valid <= 1'b1;
            if (err_count != 8'hff) begin
              err_count <= err_count + 8'd1;
            end
            state     <= S_RESP;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_job_scheduler.sv
// Scoreboard bench for aes_job_scheduler with a behavioural AES engine stand-in.
`timescale 1ns/1ps
module tb_aes_job_scheduler;

  localparam int NK      = 4;
  localparam int KW      = NK * 32;
  localparam int TIMEOUT = 64;
  localparam int EW      = 162;  // {mode, error, data[127:0], due_cycle[31:0]}
  localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] KEY = 128'h000102030405060708090a0b0c0d0e0f;

  logic          clk = 1'b0;
  logic          reset;
  logic          enc_req_valid, enc_req_ready;
  logic [127:0]  enc_data;
  logic          dec_req_valid, dec_req_ready;
  logic [127:0]  dec_data;
  logic [KW-1:0] key_in;
  logic          eng_start, eng_mode;
  logic [127:0]  eng_data;
  logic [KW-1:0] eng_key;
  logic          eng_done;
  logic [127:0]  eng_result;
  logic          rsp_valid, rsp_ready, rsp_mode, rsp_error, busy;
  logic [127:0]  rsp_data;
  logic [7:0]    err_count;
  logic [1:0]    state_dbg;

  int            total = 0;
  int            bad = 0;
  int            cyc = 0;
  int            eng_d = 12;
  int            model_err = 0;
  logic          model_last_dec = 1'b1;
  logic          rnd_ready = 1'b0;
  logic [EW-1:0] exp_q[$];
  logic          grant_q[$];

  aes_job_scheduler #(.Nk(NK), .Nr(10), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .enc_req_valid(enc_req_valid), .enc_req_ready(enc_req_ready), .enc_data(enc_data),
    .dec_req_valid(dec_req_valid), .dec_req_ready(dec_req_ready), .dec_data(dec_data),
    .key_in(key_in), .eng_start(eng_start), .eng_mode(eng_mode), .eng_data(eng_data),
    .eng_key(eng_key), .eng_done(eng_done), .eng_result(eng_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_mode(rsp_mode),
    .rsp_data(rsp_data), .rsp_error(rsp_error), .busy(busy),
    .err_count(err_count), .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Stand-in AES engine: the FIPS-197 vector pair, otherwise an arbitrary keyed mix.
  function automatic logic [127:0] eng_fn(input logic m, input logic [127:0] d, input logic [127:0] k);
    if (!m && d == PT && k == KEY) return CT;
    if (m && d == CT && k == KEY) return PT;
    return {d[63:0], d[127:64]} ^ k ^ {128{m}};
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_rsp_valid"}, rsp_valid, 0);
    check({tag, "_rsp_data"},  rsp_data, 0);
    check({tag, "_rsp_error"}, rsp_error, 0);
    check({tag, "_rsp_mode"},  rsp_mode, 0);
    check({tag, "_eng_start"}, eng_start, 0);
    check({tag, "_eng_data"},  eng_data, 0);
    check({tag, "_eng_key"},   eng_key, 0);
    check({tag, "_eng_mode"},  eng_mode, 0);
    check({tag, "_err_count"}, err_count, 0);
    check({tag, "_busy"},      busy, 0);
    check({tag, "_state_dbg_idle"}, (state_dbg != 2'd0), busy);
    check({tag, "_readies"},   {enc_req_ready, dec_req_ready}, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    enc_req_valid = 1'b0;
    dec_req_valid = 1'b0;
    #2 reset = 1'b1;
    #1 check_all_zero("reset_async");
    exp_q.delete();
    grant_q.delete();
    model_err = 0;
    model_last_dec = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(exp_q.size() == 0 && !busy && !rsp_valid) && n < budget);
    if (n >= budget) fail_now("idle_wait_expired");
  endtask

  task automatic wait_any_ready(input int budget);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(enc_req_ready || dec_req_ready) && n < budget);
    if (n >= budget) fail_now("accept_wait_expired");
  endtask

  // Drive one request; after acceptance scramble data/key to prove they were latched.
  task automatic run_job(input logic m, input logic [127:0] d, input logic [127:0] k, input int dly);
    eng_d = dly;
    @(posedge clk);
    #1;
    key_in = k;
    if (m) begin dec_data = d; dec_req_valid = 1'b1; end
    else   begin enc_data = d; enc_req_valid = 1'b1; end
    wait_any_ready(50);
    @(posedge clk);
    #1;
    enc_req_valid = 1'b0;
    dec_req_valid = 1'b0;
    enc_data = rnd128();
    dec_data = rnd128();
    key_in = rnd128();
    wait_idle(400);
  endtask

  // ---------------- engine model ----------------
  initial begin
    logic [127:0] r;
    int d;
    eng_done = 1'b0;
    eng_result = rnd128();
    forever begin
      @(negedge clk);
      if (eng_start === 1'b1) begin
        d = eng_d;
        r = eng_fn(eng_mode, eng_data, eng_key);
        if (d > 0) begin
          repeat (d) @(posedge clk);
          #1;
          eng_done = 1'b1;
          eng_result = r;
          @(posedge clk);
          #1;
          eng_done = 1'b0;
          eng_result = rnd128();
        end
      end
    end
  end

  // ---------------- accept monitor: pushes expectations ----------------
  initial begin
    logic m, err, want_dec;
    logic [127:0] d, dexp;
    int lat;
    forever begin
      @(negedge clk);
      if (!reset) begin
        check("ready_onehot", enc_req_ready & dec_req_ready, 0);
        if (enc_req_ready || dec_req_ready) begin
          want_dec = dec_req_valid & (!enc_req_valid | !model_last_dec);
          check("grant_choice", dec_req_ready, want_dec);
          m = dec_req_ready;
          model_last_dec = m;
          d = m ? dec_data : enc_data;
          err = (eng_d == 0) || (eng_d > TIMEOUT - 1);
          dexp = err ? 128'h0 : eng_fn(m, d, key_in);
          lat = err ? TIMEOUT + 1 : eng_d + 2;
          exp_q.push_back({m, err, dexp, 32'(cyc + lat)});
          grant_q.push_back(m);
        end
      end
    end
  end

  // ---------------- response monitor: scoreboard ----------------
  initial begin
    logic prev_v, prev_start;
    logic [EW-1:0] e;
    prev_v = 1'b0;
    prev_start = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_v = 1'b0;
        prev_start = 1'b0;
      end else begin
        if (eng_start) check("start_single_cycle", prev_start, 0);
        if (rsp_valid && !prev_v) begin
          if (exp_q.size() == 0) fail_now("rsp_unexpected");
          else check("rsp_latency", cyc, exp_q[0][31:0]);
        end
        if (rsp_valid && rsp_ready && exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("rsp_mode", rsp_mode, e[161]);
          check("rsp_error", rsp_error, e[160]);
          check("rsp_data", rsp_data, e[159:32]);
          if (e[160] && model_err < 255) model_err++;
          check("err_count", err_count, model_err);
        end
        prev_v = rsp_valid;
        prev_start = eng_start;
      end
    end
  end

  // Random consumer backpressure when enabled.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rnd_ready) rsp_ready = 1'($urandom_range(0, 1));
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int n;
    logic [127:0] bp_exp;
    reset = 1'b1;
    enc_req_valid = 1'b0;
    dec_req_valid = 1'b0;
    enc_data = '0;
    dec_data = '0;
    key_in = '0;
    rsp_ready = 1'b1;
    @(negedge clk);
    check_all_zero("reset_init");
    @(posedge clk);
    #1 reset = 1'b0;

    // Known vectors, D = 12.
    run_job(1'b0, PT, KEY, 12);
    run_job(1'b1, CT, KEY, 12);

    // Both valid held for four jobs: ENC, DEC, ENC, DEC.
    do_reset();
    eng_d = 3;
    @(posedge clk);
    #1;
    enc_data = rnd128();
    dec_data = rnd128();
    key_in = rnd128();
    enc_req_valid = 1'b1;
    dec_req_valid = 1'b1;
    n = 0;
    while (grant_q.size() < 4 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) fail_now("rr_wait_expired");
    @(posedge clk);
    #1;
    enc_req_valid = 1'b0;
    dec_req_valid = 1'b0;
    wait_idle(100);
    check("rr_count", grant_q.size(), 4);
    for (int i = 0; i < 4 && i < grant_q.size(); i++) check("rr_order", grant_q[i], i % 2);

    // Timeout handling and boundaries; 300 timeouts in total saturate err_count.
    do_reset();
    run_job(1'b0, rnd128(), rnd128(), 0);
    check("err_after_first_timeout", err_count, 1);
    run_job(1'b1, rnd128(), rnd128(), 63);
    run_job(1'b0, rnd128(), rnd128(), 64);
    run_job(1'b1, rnd128(), rnd128(), 1);
    for (int i = 0; i < 298; i++) run_job(1'($urandom_range(0, 1)), rnd128(), rnd128(), 0);
    check("err_saturated", err_count, 255);

    // Backpressure with a second encrypt request waiting.
    eng_d = 5;
    rsp_ready = 1'b0;
    @(posedge clk);
    #1;
    enc_data = rnd128();
    key_in = rnd128();
    bp_exp = eng_fn(1'b0, enc_data, key_in);
    enc_req_valid = 1'b1;
    wait_any_ready(50);
    @(posedge clk);
    #1;
    enc_data = rnd128();
    key_in = rnd128();
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rsp_valid && n < 50);
    if (n >= 50) fail_now("bp_rsp_wait_expired");
    for (int i = 0; i < 10; i++) begin
      check("bp_rsp_valid", rsp_valid, 1);
      check("bp_rsp_data", rsp_data, bp_exp);
      check("bp_enc_ready", enc_req_ready, 0);
      check("bp_busy", busy, 1);
      @(negedge clk);
    end
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("bp_accept_after_release", enc_req_ready, 1);
    @(posedge clk);
    #1 enc_req_valid = 1'b0;
    wait_idle(100);

    // Reset in WAIT, then a late eng_done while idle.
    eng_d = 30;
    @(posedge clk);
    #1;
    enc_data = rnd128();
    enc_req_valid = 1'b1;
    wait_any_ready(50);
    @(posedge clk);
    #1 enc_req_valid = 1'b0;
    repeat (10) @(negedge clk);
    do_reset();
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!eng_done && n < 60);
    if (n >= 60) fail_now("late_done_wait_expired");
    check("late_done_rsp_valid", rsp_valid, 0);
    check("late_done_busy", busy, 0);
    @(negedge clk);
    check("late_done_after_rsp_valid", rsp_valid, 0);
    run_job(1'b0, PT, KEY, 7);

    // Randomized mix with random consumer backpressure.
    rnd_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      int sel, r;
      sel = $urandom_range(0, 2);
      r = $urandom_range(0, 9);
      eng_d = (r == 0) ? 0 : (r == 1) ? 63 : $urandom_range(1, 20);
      @(posedge clk);
      #1;
      enc_data = rnd128();
      dec_data = rnd128();
      key_in = rnd128();
      enc_req_valid = (sel != 1);
      dec_req_valid = (sel != 0);
      wait_any_ready(50);
      @(posedge clk);
      #1;
      enc_req_valid = 1'b0;
      dec_req_valid = 1'b0;
      enc_data = rnd128();
      dec_data = rnd128();
      wait_idle(400);
    end
    rnd_ready = 1'b0;
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    check("final_queue_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
